// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus: upstream handshake and payload from decode,
// stall/kill controls, downstream handshake and decoded fields to execute,
// plus the starvation counter. The register itself connects through the
// slave modport; the driving environment uses the master modport.
interface id_ex_pipe_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_rdata1;
  logic [XLEN-1:0]  in_rdata2;
  logic [XLEN-1:0]  in_imm;

  logic             hold;
  logic             flush;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_rdata1;
  logic [XLEN-1:0]  out_rdata2;
  logic [XLEN-1:0]  out_imm;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [6:0]       out_funct7;
  logic [2:0]       out_funct3;

  logic [CNT_W-1:0] starve_cnt;

  modport master (
    output in_valid, in_pc, in_instr, in_rdata1, in_rdata2, in_imm,
    output hold, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rdata1, out_rdata2, out_imm,
    input  out_rs1, out_rs2, out_rd, out_funct7, out_funct3, starve_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_rdata1, in_rdata2, in_imm,
    input  hold, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rdata1, out_rdata2, out_imm,
    output out_rs1, out_rs2, out_rd, out_funct7, out_funct3, starve_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshakes on both sides.
// Register fields are extracted from the instruction at acceptance time so
// execute sees rs1/rs2/rd/funct7/funct3 directly.
//
// Build option: define ID_EX_PIPE_REG_SKID_EN to add a second (skid) entry.
// With the skid entry, in_ready does not depend on out_ready, which breaks
// the combinational ready path from execute back to decode. Without it the
// block is a single slot and in_ready is combinational on out_ready.
//
// STALL_MODE selects what hold does to an emptied output slot:
//   0 = leave the data fields at their last values,
//   1 = zero them so execute sees a clean bubble.
module id_ex_pipe_reg #(
  parameter int XLEN       = 32,
  parameter int STALL_MODE = 0,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             reset,
  id_ex_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
  } entry_t;

  entry_t           in_entry;
  entry_t           out_q;
  entry_t           out_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  logic             in_ready_int;
  logic             accept;
  logic             slot_free;
  logic             bubble_zero;

`ifdef ID_EX_PIPE_REG_SKID_EN
  entry_t           skid_q;
  entry_t           skid_d;
  logic             skid_valid_q;
  logic             skid_valid_d;
`endif

  // Decode the incoming instruction into the fields execute needs
  always_comb begin
    in_entry        = '0;
    in_entry.pc     = bus.in_pc;
    in_entry.rdata1 = bus.in_rdata1;
    in_entry.rdata2 = bus.in_rdata2;
    in_entry.imm    = bus.in_imm;
    in_entry.rs1    = bus.in_instr[19:15];
    in_entry.rs2    = bus.in_instr[24:20];
    in_entry.rd     = bus.in_instr[11:7];
    in_entry.funct7 = bus.in_instr[31:25];
    in_entry.funct3 = bus.in_instr[14:12];
  end

  // Upstream ready: blocked by hold, flush and reset; otherwise limited by free storage
  always_comb begin
    in_ready_int = 1'b0;
`ifdef ID_EX_PIPE_REG_SKID_EN
    in_ready_int = !skid_valid_q && !bus.hold && !bus.flush && !reset;
`else
    in_ready_int = !bus.hold && !bus.flush && !reset &&
                   (!out_valid_q || bus.out_ready);
`endif
  end

  assign accept      = bus.in_valid && in_ready_int;
  assign slot_free   = !out_valid_q || bus.out_ready;
  assign bubble_zero = (STALL_MODE == 1) && bus.hold;

  // Next state of the output slot (and skid entry): flush kills, otherwise refill a free slot
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
`ifdef ID_EX_PIPE_REG_SKID_EN
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
`endif
    if (bus.flush) begin
      out_valid_d = 1'b0;
`ifdef ID_EX_PIPE_REG_SKID_EN
      skid_valid_d = 1'b0;
`endif
      if (bubble_zero) begin
        out_d = '0;
      end
    end else if (slot_free) begin
`ifdef ID_EX_PIPE_REG_SKID_EN
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        if (bubble_zero) begin
          out_d = '0;
        end
      end
`else
      if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        if (bubble_zero) begin
          out_d = '0;
        end
      end
`endif
    end else begin
`ifdef ID_EX_PIPE_REG_SKID_EN
      if (accept) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
`endif
    end
  end

  // Count cycles where execute was ready but had nothing to do, saturating at all-ones
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (bus.out_ready && !out_valid_q && !bus.hold && (starve_cnt_q != {CNT_W{1'b1}})) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset that overrides every other control
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      starve_cnt_q <= '0;
`ifdef ID_EX_PIPE_REG_SKID_EN
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
`endif
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      starve_cnt_q <= starve_cnt_d;
`ifdef ID_EX_PIPE_REG_SKID_EN
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_pc     = out_q.pc;
  assign bus.out_rdata1 = out_q.rdata1;
  assign bus.out_rdata2 = out_q.rdata2;
  assign bus.out_imm    = out_q.imm;
  assign bus.out_rs1    = out_q.rs1;
  assign bus.out_rs2    = out_q.rs2;
  assign bus.out_rd     = out_q.rd;
  assign bus.out_funct7 = out_q.funct7;
  assign bus.out_funct3 = out_q.funct3;
  assign bus.starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Testbench for id_ex_pipe_reg (STALL_MODE=1, CNT_W=4). Works for both the
// default single-slot build and the ID_EX_PIPE_REG_SKID_EN build.
// The driver issues directed then random stimulus; a monitor at each falling
// edge compares the DUT against a queue model of the pipeline contents.
module tb_id_ex_pipe_reg;

  localparam int XLEN       = 32;
  localparam int STALL_MODE = 1;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef ID_EX_PIPE_REG_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
  } exp_t;

  logic clk;
  logic reset;

  id_ex_pipe_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  id_ex_pipe_reg #(
    .XLEN(XLEN),
    .STALL_MODE(STALL_MODE),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   delivered = 0;
  int   dut_accepts = 0;
  bit   model_ok = 0;
  bit   exp_rdy;
  exp_t offer;
  exp_t disp;
  exp_t act;
  exp_t model_q[$];
  int   cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode with plain arithmetic on the instruction word
  function automatic exp_t makeExp(input logic [31:0] pc, input logic [31:0] instr,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] imm);
    exp_t e;
    e.pc     = pc;
    e.rdata1 = r1;
    e.rdata2 = r2;
    e.imm    = imm;
    e.rs1    = 5'((instr / 32768) % 32);
    e.rs2    = 5'((instr / 1048576) % 32);
    e.rd     = 5'((instr / 128) % 32);
    e.funct7 = 7'(instr / 33554432);
    e.funct3 = 3'((instr / 4096) % 8);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one set of inputs, then wait the given number of rising edges (+2 time units)
  task automatic applyStimulus(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] imm, input bit h, input bit f,
                               input bit ordy, input bit rst, input int cycles);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = instr;
    bus.in_rdata1 = r1;
    bus.in_rdata2 = r2;
    bus.in_imm    = imm;
    bus.hold      = h;
    bus.flush     = f;
    bus.out_ready = ordy;
    reset         = rst;
    offer         = makeExp(pc, instr, r1, r2, imm);
    repeat (cycles) @(posedge clk);
    if (cycles > 0) #2;
  endtask

  task automatic idle(input bit h, input bit f, input bit ordy, input bit rst, input int cycles);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, h, f, ordy, rst, cycles);
  endtask

  // Monitor and reference model: compare the current cycle, then advance the model over the next edge
  always @(negedge clk) begin
    exp_rdy = !reset && !bus.hold && !bus.flush &&
              ((DEPTH == 2) ? (model_q.size() < 2)
                            : (model_q.size() == 0 || bus.out_ready));
    act = {bus.out_pc, bus.out_rdata1, bus.out_rdata2, bus.out_imm,
           bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_funct7, bus.out_funct3};
    if (model_ok) begin
      checkOutput("out_valid", 256'(bus.out_valid), 256'(model_q.size() > 0));
      checkOutput("in_ready", 256'(bus.in_ready), 256'(exp_rdy));
      checkOutput("starve_cnt", 256'(bus.starve_cnt), 256'(cnt));
      checkOutput("out_data", 256'(act), 256'(disp));
    end
    if (bus.in_valid && bus.in_ready) dut_accepts++;
    if (reset) begin
      model_q.delete();
      disp     = '0;
      cnt      = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (bus.out_ready && model_q.size() == 0 && !bus.hold && cnt < CNT_MAX) cnt++;
      if (bus.flush) begin
        model_q.delete();
      end else begin
        if (model_q.size() > 0 && bus.out_ready) begin
          void'(model_q.pop_front());
          delivered++;
        end
        if (bus.in_valid && exp_rdy) model_q.push_back(offer);
      end
      if (model_q.size() > 0) disp = model_q[0];
      else if (STALL_MODE == 1 && bus.hold) disp = '0;
    end
  end

  // Bound on total run time
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Driver: directed scenarios first, then randomized traffic
  initial begin
    int base;
    idle(1'b0, 1'b0, 1'b1, 1'b1, 2);

    // in_ready comes up as soon as reset drops
    idle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    #1;
    checkOutput("in_ready_after_reset", 256'(bus.in_ready), 256'(1));

    // Two back-to-back instructions stream through without gaps
    applyStimulus(1'b1, 32'h0000_0010, 32'h00B5_0533, 32'h11, 32'h22, 32'h33,
                  1'b0, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("stream1_valid", 256'(bus.out_valid), 256'(1));
    checkOutput("stream1_rd", 256'(bus.out_rd), 256'(10));
    checkOutput("stream1_funct7", 256'(bus.out_funct7), 256'(7'h00));
    applyStimulus(1'b1, 32'h0000_0014, 32'h40C5_8633, 32'h44, 32'h55, 32'h66,
                  1'b0, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("stream2_valid", 256'(bus.out_valid), 256'(1));
    checkOutput("stream2_rd", 256'(bus.out_rd), 256'(12));
    checkOutput("stream2_funct7", 256'(bus.out_funct7), 256'(7'h20));

    // Backpressure: three stalled cycles with new entries offered
    base = dut_accepts;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(i * 4), 32'h0000_0000 + 32'((i + 1) * 128), 32'(i),
                    32'(i + 1), 32'(i + 2), 1'b0, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("bp_stable_rd", 256'(bus.out_rd), 256'(12));
      checkOutput("bp_stable_valid", 256'(bus.out_valid), 256'(1));
    end
    checkOutput("bp_extra_accepts", 256'(dut_accepts - base), 256'(DEPTH - 1));
    idle(1'b0, 1'b0, 1'b1, 1'b0, 4);

    // Hold after a delivered entry zeroes the slot (bubble) and blocks input
    applyStimulus(1'b1, 32'h0000_0100, 32'h0031_0093, 32'h1, 32'h2, 32'h3,
                  1'b0, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("hold_pre_pc", 256'(bus.out_pc), 256'(32'h100));
    applyStimulus(1'b1, 32'h0000_0104, 32'h0031_0113, 32'h1, 32'h2, 32'h3,
                  1'b1, 1'b0, 1'b1, 1'b0, 0);
    #1;
    checkOutput("hold_in_ready", 256'(bus.in_ready), 256'(0));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      checkOutput("hold_out_pc", 256'(bus.out_pc), 256'(0));
      checkOutput("hold_out_valid", 256'(bus.out_valid), 256'(0));
      checkOutput("hold_in_ready_stall", 256'(bus.in_ready), 256'(0));
    end
    idle(1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Flush with hold, a stalled full slot and (skid build) a full skid entry
    applyStimulus(1'b1, 32'h300, 32'h0050_0293, 32'h7, 32'h8, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 32'h304, 32'h0060_0313, 32'h7, 32'h8, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 32'h308, 32'h0070_0393, 32'h7, 32'h8, 32'h9, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("flush_out_valid", 256'(bus.out_valid), 256'(0));
    idle(1'b0, 1'b0, 1'b1, 1'b0, 3);
    checkOutput("flush_no_ghost", 256'(bus.out_valid), 256'(0));

    // Starvation counter saturates at 15 with CNT_W=4
    idle(1'b0, 1'b0, 1'b1, 1'b1, 1);
    idle(1'b0, 1'b0, 1'b1, 1'b0, 20);
    checkOutput("starve_sat", 256'(bus.starve_cnt), 256'(15));
    idle(1'b0, 1'b0, 1'b1, 1'b0, 3);
    checkOutput("starve_held", 256'(bus.starve_cnt), 256'(15));

    // Reset in the middle of a stall clears everything
    applyStimulus(1'b1, 32'h400, 32'hFFFF_FFFF, 32'hA, 32'hB, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 32'h404, 32'h0080_0413, 32'hA, 32'hB, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    checkOutput("rst_out_valid", 256'(bus.out_valid), 256'(0));
    checkOutput("rst_out_pc", 256'(bus.out_pc), 256'(0));
    checkOutput("rst_out_rd", 256'(bus.out_rd), 256'(0));
    checkOutput("rst_starve", 256'(bus.starve_cnt), 256'(0));
    idle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    #1;
    checkOutput("rst_in_ready_after", 256'(bus.in_ready), 256'(1));
    idle(1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, 1);
    end
    idle(1'b0, 1'b0, 1'b1, 1'b0, 4);
    checkOutput("drained_delivered_some", 256'(delivered > 100), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC, operands and immediate.
REQ-002 SHALL have parameter STALL_MODE, default 0: 0 = hold keeps output fields, 1 = hold zeroes them (bubble).
REQ-003 SHALL have parameter CNT_W, default 16, width of the starvation counter.
REQ-004 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, the upstream handshake from fetch/decode.
REQ-007 SHALL have inputs in_pc XLEN, in_instr 32, in_rdata1 XLEN, in_rdata2 XLEN and in_imm XLEN, the upstream payload.
REQ-008 SHALL have ports hold input 1 (combined hazard stall) and flush input 1 (branch/exception kill).
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, the downstream handshake to execute.
REQ-010 SHALL have outputs out_pc, out_rdata1, out_rdata2, out_imm (XLEN each), out_rs1 5, out_rs2 5, out_rd 5, out_funct7 7 and out_funct3 3.
REQ-011 SHALL have output starve_cnt CNT_W, a saturating count of downstream-starved cycles.

Function
REQ-012 SHALL accept an entry when in_valid && in_ready, and SHALL deliver it when out_valid && out_ready.
REQ-013 SHALL decode fields at acceptance: rs1=instr[19:15], rs2=[24:20], rd=[11:7], funct7=[31:25], funct3=[14:12].
REQ-014 SHALL present an accepted entry on the outputs one cycle after acceptance when the output slot is empty or being drained.
REQ-015 SHALL hold all output fields and out_valid stable while out_valid=1 and out_ready=0.
REQ-016 SHALL drive in_ready=0 while hold=1, flush=1 or reset=1.
REQ-017 With STALL_MODE=0, hold=1 SHALL leave out_* data fields at their last values once the slot drains, with out_valid=0.
REQ-018 With STALL_MODE=1, hold=1 SHALL zero all out_* data fields at the edge at which the slot is empty or drained, with out_valid=0.
REQ-019 flush=1 SHALL, at the next edge, clear out_valid and any buffered entry and drop any input presented that cycle; flush SHALL override hold.
REQ-020 starve_cnt SHALL increment by 1 each cycle with out_ready=1, out_valid=0 and hold=0, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-021 Entries SHALL leave in acceptance order, never duplicated and never lost except by flush or reset.

Reset
REQ-022 reset=1 at a rising edge SHALL clear out_valid, all out_* data fields, any buffered entry and starve_cnt to 0.
REQ-023 reset SHALL take priority over flush, hold and all handshakes, including an entry in flight.
REQ-024 in_ready SHALL read 1 in the first cycle after reset deasserts, provided hold=0 and flush=0.

Configuration
REQ-025 Macro ID_EX_PIPE_REG_SKID_EN SHALL select the buffering structure.
REQ-026 When defined, the block SHALL add a second skid entry, and in_ready SHALL be registered as !skid_valid && !hold && !flush.
REQ-027 When defined, an entry accepted while the output slot is full and stalled SHALL go to the skid entry, which moves to the output slot on the next out_ready=1 edge.
REQ-028 When undefined, depth SHALL be 1, and in_ready SHALL be combinational: !hold && !flush && (!out_valid || out_ready).
REQ-029 Both builds SHALL have identical throughput of 1 entry/cycle when out_ready=1 continuously.

Verification
REQ-030 Streaming: instr 0x00B50533, then 0x40C58633, back-to-back with out_ready=1 -> out_rd=10 then 12 on consecutive cycles, out_funct7=0x00 then 0x20, no gaps.
REQ-031 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable; SKID build accepts exactly 1 extra entry; all entries arrive in order when out_ready=1.
REQ-032 Hold with STALL_MODE=1: hold=1 for 2 cycles after a delivered entry with in_pc=0x100 -> out_pc=0 and out_valid=0; in_ready=0 throughout.
REQ-033 Flush with hold=1, out_valid=1 and skid full -> out_valid=0 next cycle, skid empty, the entry offered that cycle never appears.
REQ-034 Starvation: CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> starve_cnt=15, held at 15.
REQ-035 Reset mid-stall: reset=1 while out_valid=1 and out_ready=0 -> all outputs 0 next cycle; in_ready=1 the cycle after reset deasserts.
